// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program image into instruction memory.
// Stream: LEN_HI, LEN_LO (word count N, big-endian), then N words, high byte first.
// Holds the core (cpu_hold) until a complete, valid image has been written.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that is verified before the core is released.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic accept;
    assign accept = in_valid && in_ready_q;

    // State and registered-output update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    // Next-state logic; outputs are computed for the next cycle so they stay registered
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        words_d     = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
                    cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    if ({len_q[15:8], in_data} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d    = S_CHK;
`else
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        error_d    = 1'b0;
                        cpu_hold_d = 1'b0;
`endif
                    end else if ({16'd0, len_q[15:8], in_data} > DEPTH_U) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ in_data;
`endif
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = {hi_q, in_data};
                    mem_addr_d  = words_q[ADDR_W-1:0];
                    words_d     = words_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d       = chk_q ^ in_data;
`endif
                    if (words_q + 16'd1 == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d    = S_CHK;
`else
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        error_d    = 1'b0;
                        cpu_hold_d = 1'b0;
`endif
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    error_d    = (in_data != chk_q);
                    cpu_hold_d = (in_data != chk_q);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready follows the state being entered, so it drops on the edge that takes the last byte
    always_comb begin
        in_ready_d = 1'b0;
        unique case (state_d)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: in_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                                    in_ready_d = 1'b1;
`endif
            default:                                  in_ready_d = 1'b0;
        endcase
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized program images checked
// against a stream-level reference model (expected write list and final status).
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    wr_t               exp_wr[$];
    logic [15:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic              exp_err;
    logic              exp_hold;
    logic [15:0]       exp_words;
    logic              loading = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: derive writes and final status directly from the byte stream
    task automatic model_load(input bq_t s);
        int n;
        n = {s[0], s[1]};
        exp_wr.delete();
        if (n > DEPTH) begin
            exp_err   = 1'b1;
            exp_hold  = 1'b1;
            exp_words = 16'd0;
        end else begin
            for (int i = 0; i < n; i++) begin
                wr_t w;
                w.addr = ADDR_W'(i);
                w.data = {s[2+2*i], s[3+2*i]};
                exp_wr.push_back(w);
            end
            exp_words = 16'(n);
            exp_err   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 2; i < 2 + 2 * n; i++) x ^= s[i];
                exp_err = (s[2+2*n] != x);
            end
`endif
            exp_hold = exp_err;
        end
    endtask

    // Random image of n words; with checksum enabled a trailer is appended (sometimes corrupted)
    task automatic make_stream(input int n, output bq_t s);
        logic [15:0] nn;
        logic [7:0]  b;
        nn = 16'(n);
        s = {};
        s.push_back(nn[15:8]);
        s.push_back(nn[7:0]);
        if (n <= DEPTH) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            logic [7:0] x;
            x = 8'h00;
`endif
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom);
                s.push_back(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x ^= b;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
            s.push_back(x);
`endif
        end
    endtask

    // mode 0: valid always high; 1: valid every other cycle; 2: random valid plus ignored start pulses
    task automatic run_load(input bq_t s, input int mode, input int nbytes);
        int   idx;
        int   cyc;
        logic v;
        logic tog;
        idx = 0;
        cyc = 0;
        tog = 1'b0;
        model_load(s);
        got_data.delete();
        got_addr.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        loading = 1'b1;
        check("start_clears_done", {31'd0, done}, 32'd0);
        check("start_sets_hold", {31'd0, cpu_hold}, 32'd1);
        while (idx < nbytes) begin
            @(negedge clk);
            start = 1'b0;
            tog   = ~tog;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? s[idx] : 8'($urandom);
            if (mode == 2 && $urandom_range(0, 5) == 0) start = 1'b1;
            if (v && in_ready) idx++;
            cyc++;
            if (cyc > 4 * nbytes + 50) begin
                check("stream_timeout", 32'(idx), 32'(nbytes));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        if (nbytes < s.size()) return;
        check("ready_drops_after_last", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            check("no_extra_accept", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("error", {31'd0, error}, {31'd0, exp_err});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
        check("words_loaded", {16'd0, words_loaded}, {16'd0, exp_words});
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        loading = 1'b0;
    endtask

    // Per-cycle compare of memory writes and hold/error status against the model
    always @(negedge clk) begin
        if (!rst) begin
            last_addr <= '0;
        end else begin
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {31'd0, mem_we}, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", {16'd0, mem_wdata}, {16'd0, w.data});
                end
                last_addr <= mem_addr;
            end else begin
                check("addr_hold", 32'(mem_addr), 32'(last_addr));
            end
            if (loading && !done) begin
                check("hold_while_loading", {31'd0, cpu_hold}, 32'd1);
                check("no_error_while_loading", {31'd0, error}, 32'd0);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        bq_t s;
        bq_t basic;
        int  n;
        int  r;

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset then idle; a start pulse while rst is low must be ignored
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_in_ready", {31'd0, in_ready}, 32'd0);
            check("idle_hold", {31'd0, cpu_hold}, 32'd1);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // Basic load
        basic = {8'h00, 8'h02, 8'h04, 8'h90, 8'h2D, 8'h10};
`ifdef IMEM_LOADER_CHECKSUM_EN
        basic.push_back(8'hA9);
`endif
        run_load(basic, 0, basic.size());
        check("basic_nwr", 32'(got_data.size()), 32'd2);
        check("basic_addr0", 32'(got_addr[0]), 32'd0);
        check("basic_data0", {16'd0, got_data[0]}, 32'h0490);
        check("basic_addr1", 32'(got_addr[1]), 32'd1);
        check("basic_data1", {16'd0, got_data[1]}, 32'h2D10);
        check("basic_err", {31'd0, error}, 32'd0);
        check("basic_hold", {31'd0, cpu_hold}, 32'd0);
        check("basic_words", {16'd0, words_loaded}, 32'd2);

        // Same stream with valid toggling
        run_load(basic, 1, basic.size());
        check("stall_nwr", 32'(got_data.size()), 32'd2);
        check("stall_data0", {16'd0, got_data[0]}, 32'h0490);
        check("stall_data1", {16'd0, got_data[1]}, 32'h2D10);

        // Overflow: 1025 words requested
        s = {8'h04, 8'h01};
        run_load(s, 0, s.size());
        check("ovf_nwr", 32'(got_data.size()), 32'd0);
        check("ovf_err", {31'd0, error}, 32'd1);
        check("ovf_hold", {31'd0, cpu_hold}, 32'd1);

        // Zero length, then a one-word reload
        s = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load(s, 0, s.size());
        check("zero_nwr", 32'(got_data.size()), 32'd0);
        check("zero_hold", {31'd0, cpu_hold}, 32'd0);
        s = {8'h00, 8'h01, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h66);
`endif
        run_load(s, 2, s.size());
        check("reload_data", {16'd0, got_data[0]}, 32'hABCD);
        check("reload_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad trailer: words remain written, core stays held
        s = {8'h00, 8'h02, 8'h04, 8'h90, 8'h2D, 8'h10, 8'h00};
        run_load(s, 0, s.size());
        check("chk_bad_err", {31'd0, error}, 32'd1);
        check("chk_bad_hold", {31'd0, cpu_hold}, 32'd1);
        check("chk_bad_nwr", 32'(got_data.size()), 32'd2);
`endif

        // Reset mid-load after three bytes
        run_load(basic, 0, 3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        check("mid_rst_words", {16'd0, words_loaded}, 32'd0);
        loading = 1'b0;
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b1;

        // Randomized images
        for (int it = 0; it < 14; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(DEPTH + 1, 65535);
            else             n = $urandom_range(1, 12);
            make_stream(n, s);
            run_load(s, $urandom_range(0, 2), s.size());
        end

        // Full-depth boundary
        make_stream(DEPTH, s);
        run_load(s, 0, s.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
